// File: rtl/bidir_port_ctrl_if.sv
// Requester-side bundle for bidir_port_ctrl: two req/ack requesters plus bus status.
// The master modport is the requester side; slave is the controller side.
interface bidir_port_ctrl_if #(
    parameter int W = 8
);
    logic         req0;
    logic         we0;
    logic [W-1:0] wdata0;
    logic         ack0;
    logic [W-1:0] rdata0;
    logic         req1;
    logic         we1;
    logic [W-1:0] wdata1;
    logic         ack1;
    logic [W-1:0] rdata1;
    logic         busy;
    logic         dir_out;

    modport master (
        output req0, we0, wdata0, req1, we1, wdata1,
        input  ack0, rdata0, ack1, rdata1, busy, dir_out
    );

    modport slave (
        input  req0, we0, wdata0, req1, we1, wdata1,
        output ack0, rdata0, ack1, rdata1, busy, dir_out
    );
endinterface

// File: rtl/bidir_port_ctrl.sv
// Round-robin owner of a shared bidirectional pad: write = 1+HOLD_CYC cycles to ack, read = 1+SAMPLE_CYC,
// +TURN_CYC on direction change; requesters hold req until a one-cycle ack, no back-to-back grants.
module bidir_port_ctrl #(
    parameter int W          = 8,
    parameter int HOLD_CYC   = 2,
    parameter int SAMPLE_CYC = 2,
    parameter int TURN_CYC   = 1
) (
    input  logic               clk,
    input  logic               rst,
    bidir_port_ctrl_if.slave   bus,
    inout  wire  [W-1:0]       io_pad
);
    localparam int CW = 8;

    typedef enum logic [2:0] {IDLE, TURN, DRIVE, SAMPLE, ACK} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          gnt, gnt_n;
    logic          op, op_n;
    logic          dir_q, dir_n;
    logic          last_grant, lg_n;
    logic [W-1:0]  pad_q, pad_n;
    logic [W-1:0]  rdata0_q, rd0_n;
    logic [W-1:0]  rdata1_q, rd1_n;
    logic          oe;
    logic          g;
    logic          g_we;

    function automatic state_t phase_state(input logic wr);
        return wr ? DRIVE : SAMPLE;
    endfunction

    function automatic logic [CW-1:0] phase_cnt(input logic wr);
        return wr ? CW'(HOLD_CYC - 1) : CW'(SAMPLE_CYC - 1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            gnt        <= 1'b0;
            op         <= 1'b0;
            dir_q      <= 1'b0;
            last_grant <= 1'b1;
            pad_q      <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            gnt        <= gnt_n;
            op         <= op_n;
            dir_q      <= dir_n;
            last_grant <= lg_n;
            pad_q      <= pad_n;
            rdata0_q   <= rd0_n;
            rdata1_q   <= rd1_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        gnt_n   = gnt;
        op_n    = op;
        dir_n   = dir_q;
        lg_n    = last_grant;
        pad_n   = pad_q;
        rd0_n   = rdata0_q;
        rd1_n   = rdata1_q;
        g       = 1'b0;
        g_we    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    // On contention the requester not served last time wins.
                    g     = (bus.req0 && bus.req1) ? ~last_grant : bus.req1;
                    g_we  = g ? bus.we1 : bus.we0;
                    gnt_n = g;
                    lg_n  = g;
                    op_n  = g_we;
                    if (g_we) pad_n = g ? bus.wdata1 : bus.wdata0;
                    if (g_we != dir_q) begin
                        state_n = TURN;
                        cnt_n   = CW'(TURN_CYC - 1);
                    end else begin
                        state_n = phase_state(g_we);
                        cnt_n   = phase_cnt(g_we);
                    end
                end
            end
            TURN: begin
                if (cnt == '0) begin
                    dir_n   = op;
                    state_n = phase_state(op);
                    cnt_n   = phase_cnt(op);
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            DRIVE: begin
                if (cnt == '0) state_n = ACK;
                else           cnt_n   = cnt - CW'(1);
            end
            SAMPLE: begin
                if (cnt == '0) begin
                    if (gnt) rd1_n = io_pad;
                    else     rd0_n = io_pad;
                    state_n = ACK;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            ACK:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Decoded from state so reset drops the pad driver and acks without waiting for a clock.
    assign oe          = (state == DRIVE);
    assign io_pad      = oe ? pad_q : {W{1'bz}};
    assign bus.ack0    = (state == ACK) && !gnt;
    assign bus.ack1    = (state == ACK) &&  gnt;
    assign bus.rdata0  = rdata0_q;
    assign bus.rdata1  = rdata1_q;
    assign bus.busy    = (state != IDLE);
    assign bus.dir_out = dir_q;
endmodule

// File: tb/tb_bidir_port_ctrl.sv
// Directed bench for bidir_port_ctrl with a queue scoreboard popped by a negedge monitor on every ack.
module tb_bidir_port_ctrl;
    logic       clk;
    logic       rst;
    logic [7:0] tb_pad;
    wire  [7:0] io_pad;

    bidir_port_ctrl_if #(.W(8)) bus ();

    bidir_port_ctrl #(.W(8), .HOLD_CYC(2), .SAMPLE_CYC(2), .TURN_CYC(1)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus.slave),
        .io_pad (io_pad)
    );

    // Far end of the pad: drives tb_pad whenever the controller releases it.
    assign io_pad = dut.oe ? {8{1'bz}} : tb_pad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         id;
        bit         rd;
        logic [7:0] dat;
        int         oe_cyc;
        bit         dir;
        int         gap;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_ack = 0;
    int   oe_cnt = 0;
    bit   prev_ack = 0;
    int   lat;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            oe_cnt   = 0;
            prev_ack = 0;
        end else begin
            cyc++;
            if (prev_ack) chk("busy_after_ack", int'(bus.busy), 0);
            prev_ack = 0;
            if (dut.oe) begin
                oe_cnt++;
                if (q.size() == 0) chk("unexpected_drive", 1, 0);
                else               chk("pad_drive", int'(io_pad), int'(q[0].dat));
            end
            if (bus.ack0 || bus.ack1) begin
                prev_ack = 1;
                chk("ack_exclusive", int'(bus.ack0 && bus.ack1), 0);
                if (q.size() == 0) begin
                    chk("unexpected_ack", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("ack_id", bus.ack1 ? 1 : 0, e.id);
                    if (e.rd) chk("rdata", int'(e.id != 0 ? bus.rdata1 : bus.rdata0), int'(e.dat));
                    chk("oe_cycles", oe_cnt, e.oe_cyc);
                    chk("dir_out", int'(bus.dir_out), int'(e.dir));
                    if (e.gap != 0) chk("ack_spacing", cyc - last_ack, e.gap);
                end
                oe_cnt   = 0;
                last_ack = cyc;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state();
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_ack0", int'(bus.ack0), 0);
        chk("rst_ack1", int'(bus.ack1), 0);
        chk("rst_dir", int'(bus.dir_out), 0);
        chk("rst_oe", int'(dut.oe), 0);
        chk("rst_rdata0", int'(bus.rdata0), 0);
        chk("rst_rdata1", int'(bus.rdata1), 0);
    endtask

    // Counts edges until n acks are seen, drops both reqs in the last ack cycle.
    task automatic hold_reqs(input int n, output int first_lat);
        int seen = 0;
        first_lat = -1;
        for (int i = 1; i <= 60; i++) begin
            step();
            if (bus.ack0 || bus.ack1) begin
                seen++;
                if (seen == 1) first_lat = i;
                if (seen == n) break;
            end
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        if (seen != n) chk("ack_timeout", seen, n);
    endtask

    initial begin
        rst = 1'b1;
        tb_pad = 8'h00;
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.wdata0 = 8'h00;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.wdata1 = 8'h00;
        repeat (2) step();
        check_reset_state();
        rst = 1'b0;
        step();

        // Single write from reset: direction 0->1 needs one TURN cycle.
        q.push_back('{0, 1'b0, 8'hA5, 2, 1'b1, 0});
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.wdata0 = 8'hA5;
        hold_reqs(1, lat);
        chk("t1_latency", lat, 4);
        repeat (2) step();

        // Read after write: TURN then two SAMPLE cycles, pad never driven.
        tb_pad = 8'h3C;
        q.push_back('{0, 1'b1, 8'h3C, 0, 1'b0, 0});
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.wdata0 = 8'hFF;
        hold_reqs(1, lat);
        chk("t2_latency", lat, 4);
        repeat (2) step();

        // Both requesters held as writes from reset: alternating grants.
        rst = 1'b1;
        step();
        check_reset_state();
        rst = 1'b0;
        step();
        q.push_back('{0, 1'b0, 8'h11, 2, 1'b1, 0});
        q.push_back('{1, 1'b0, 8'h22, 2, 1'b1, 4});
        q.push_back('{0, 1'b0, 8'h11, 2, 1'b1, 4});
        q.push_back('{1, 1'b0, 8'h22, 2, 1'b1, 4});
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.wdata0 = 8'h11;
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.wdata1 = 8'h22;
        hold_reqs(4, lat);
        chk("t3_latency", lat, 4);
        repeat (2) step();

        // Back-to-back writes by requester 1 in the same direction.
        q.push_back('{1, 1'b0, 8'h5A, 2, 1'b1, 0});
        q.push_back('{1, 1'b0, 8'h5A, 2, 1'b1, 4});
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.wdata1 = 8'h5A;
        hold_reqs(2, lat);
        chk("t4_latency", lat, 3);
        repeat (2) step();

        // Reset during the second DRIVE cycle aborts without ack.
        q.push_back('{0, 1'b0, 8'h77, 2, 1'b1, 0});
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.wdata0 = 8'h77;
        step();
        step();
        chk("t5_in_drive", int'(dut.oe), 1);
        rst = 1'b1;
        #1;
        chk("t5_rst_oe", int'(dut.oe), 0);
        chk("t5_rst_busy", int'(bus.busy), 0);
        chk("t5_rst_ack0", int'(bus.ack0), 0);
        chk("t5_rst_dir", int'(bus.dir_out), 0);
        q.delete();
        step();
        step();
        rst = 1'b0;
        q.push_back('{0, 1'b0, 8'h77, 2, 1'b1, 0});
        hold_reqs(1, lat);
        chk("t5_latency", lat, 4);
        repeat (2) step();

        // Requester 1 read dropped after grant still completes; requester 0 next.
        tb_pad = 8'hC3;
        q.push_back('{1, 1'b1, 8'hC3, 0, 1'b0, 0});
        q.push_back('{0, 1'b0, 8'h99, 2, 1'b1, 5});
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.wdata0 = 8'h99;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.wdata1 = 8'h00;
        step();
        step();
        bus.req1 = 1'b0;
        bus.we1  = 1'b1;
        hold_reqs(2, lat);
        repeat (3) step();

        chk("queue_drained", q.size(), 0);
        chk("final_rdata0", int'(bus.rdata0), 8'h00);
        chk("final_rdata1", int'(bus.rdata1), 8'hC3);
        chk("final_busy", int'(bus.busy), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bidir_port_ctrl.md
Name: bidir_port_ctrl

Overview:
- Controller that shares one W-bit bidirectional pad bus between two requesters.
- Each requester issues single read or write transactions over a req/ack handshake.
- Block arbitrates round-robin, owns the pad output-enable, inserts bus-turnaround cycles on direction change, and holds/samples the pad for fixed cycle counts.
- Sits between internal logic and the bidirectional pin.

Parameters:
W, 8, pad/data width
HOLD_CYC, 2, cycles pad is driven per write (>=1)
SAMPLE_CYC, 2, cycles waited before a read capture (>=1)
TURN_CYC, 1, idle cycles (oe low) inserted on direction change (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req0  input  1  requester 0 transaction request, level, held until ack0
we0  input  1  requester 0: 1 = write, 0 = read; valid with req0
wdata0  input  W  requester 0 write data; valid with req0
ack0  output  1  one-cycle completion pulse to requester 0
rdata0  output  W  requester 0 read data; valid when ack0=1, held until next read by requester 0
req1, we1, wdata1, ack1, rdata1  same as above for requester 1
io_pad  inout  W  bidirectional pad bus; driven with pad_q when oe=1, else high-Z
busy  output  1  high whenever state != IDLE
dir_out  output  1  current bus direction: 1 = last op was write, 0 = read

Behaviour:
- Reset (async, immediate): state=IDLE, oe=0 (io_pad high-Z), ack0=ack1=0, rdata0=rdata1=0, busy=0, dir_out=0, pad_q=0, cnt=0, last_grant=1 (requester 0 wins first contest).
- States: IDLE, TURN, DRIVE, SAMPLE, ACK.
- IDLE: if any req is high at a clock edge, grant it. If both are high, grant the one != last_grant, then update last_grant. At the grant edge latch gnt, op=we_g, and pad_q=wdata_g (writes only).
  - If op != dir_out: go to TURN with cnt=TURN_CYC-1.
  - Otherwise go to DRIVE (write) with cnt=HOLD_CYC-1, or SAMPLE (read) with cnt=SAMPLE_CYC-1.
- TURN: oe=0. Decrement cnt. At cnt=0, set dir_out=op and go to DRIVE or SAMPLE with the counts above.
- DRIVE: oe=1, io_pad=pad_q. Decrement cnt. At cnt=0 go to ACK.
- SAMPLE: oe=0. Decrement cnt. At cnt=0 capture io_pad into rdata of the granted requester, then go to ACK.
- ACK: oe=0, ack_gnt=1 for exactly one cycle, then IDLE. A new grant can occur at the edge ending the first IDLE cycle after ACK; there are no back-to-back grants out of ACK.
- Latency (req sampled at IDLE edge k, same direction): write has oe high in cycles k+1..k+HOLD_CYC and ack in cycle k+HOLD_CYC+1. Read has ack in cycle k+SAMPLE_CYC+1. A direction change adds TURN_CYC cycles.
- oe is never high in TURN, SAMPLE, ACK or IDLE, so the pad is always high-Z for at least TURN_CYC cycles between a write drive and a read sample.
- Requester drops req mid-transaction: the transaction still completes and ack still pulses. we/wdata changes after grant are ignored.
- Requester re-asserts immediately after ack while the other is waiting: the other wins (round-robin).
- Ungranted ack is always 0. ack0 and ack1 are never high together.
- Reset asserted mid-transaction: immediate return to reset values, oe=0 at once, no ack issued for the aborted transaction.

Test Plan:
- Reset, then req0=1, we0=1, wdata0=8'hA5, defaults: one TURN cycle (dir 0->1), io_pad=A5 for 2 cycles, ack0 pulse 1 cycle, dir_out=1, busy low after ack.
- Then req0 read while bench drives io_pad=8'h3C whenever oe=0: TURN 1 cycle, SAMPLE 2 cycles, rdata0=3C with ack0, dir_out=0, oe never high during the read.
- req0 and req1 both held as writes (11, 22) from reset: grant order 0,1,0,1 across four transactions. Each ack goes only to its own requester. Writes after the first have no TURN.
- Back-to-back writes by requester 1: no TURN cycles between them. Ack spacing is HOLD_CYC+2 cycles (grant-to-ack HOLD_CYC+1, plus one IDLE cycle after ACK).
- Assert rst in the 2nd DRIVE cycle: io_pad goes high-Z immediately, no ack, busy=0. After release, a pending req0 is granted normally.
- req1 dropped one cycle after grant (read): ack1 still pulses and rdata1 is updated. req0 is granted next.
